// File: rtl/semaforo_pkg.sv
// Shared types and lamp encodings for the intersection phase sequencer.
// Lamp bus: light i (0=N, 1=S, 2=E, 3=W) owns bits 3i+2 red, 3i+1 amber, 3i green.
package semaforo_pkg;

  typedef enum logic [2:0] {
    ALLRED_START = 3'd0,
    NS_GREEN     = 3'd1,
    NS_AMBER     = 3'd2,
    ALLRED_1     = 3'd3,
    EW_GREEN     = 3'd4,
    EW_AMBER     = 3'd5,
    ALLRED_2     = 3'd6,
    FLASH        = 3'd7
  } fase_t;

  localparam int N_G = 0;
  localparam int N_A = 1;
  localparam int N_R = 2;
  localparam int S_G = 3;
  localparam int S_A = 4;
  localparam int S_R = 5;
  localparam int E_G = 6;
  localparam int E_A = 7;
  localparam int E_R = 8;
  localparam int W_G = 9;
  localparam int W_A = 10;
  localparam int W_R = 11;

  localparam logic [11:0] ALL_RED  = 12'((1 << N_R) | (1 << S_R) | (1 << E_R) | (1 << W_R)); // 0x924
  localparam logic [11:0] NS_G     = 12'((1 << N_G) | (1 << S_G) | (1 << E_R) | (1 << W_R)); // 0x909
  localparam logic [11:0] NS_A     = 12'((1 << N_A) | (1 << S_A) | (1 << E_R) | (1 << W_R)); // 0x912
  localparam logic [11:0] EW_G     = 12'((1 << N_R) | (1 << S_R) | (1 << E_G) | (1 << W_G)); // 0x264
  localparam logic [11:0] EW_A     = 12'((1 << N_R) | (1 << S_R) | (1 << E_A) | (1 << W_A)); // 0x4A4
  localparam logic [11:0] FLASH_ON = 12'((1 << N_A) | (1 << S_A) | (1 << E_A) | (1 << W_A)); // 0x492

endpackage

// File: rtl/semaforo_ctrl_tick_gen.sv
// Half-second prescaler: one-clock tick every HALF_SEC_CYCLES clocks,
// realigned to zero whenever restart is asserted.
module tick_gen #(
  parameter int unsigned HALF_SEC_CYCLES = 13_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned PW = (HALF_SEC_CYCLES > 1) ? $clog2(HALF_SEC_CYCLES) : 1;
  localparam logic [PW-1:0] LAST = PW'(HALF_SEC_CYCLES - 1);

  logic [PW-1:0] presc_q, presc_d;

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (restart || (presc_q == LAST)) presc_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) presc_q <= '0;
    else      presc_q <= presc_d;
  end

  assign tick = (presc_q == LAST);

endmodule

// File: rtl/semaforo_ctrl.sv
// Four-approach traffic-light phase sequencer with ESP32 green-time select
// and flashing-amber override.
module semaforo_ctrl
  import semaforo_pkg::*;
#(
  parameter int unsigned HALF_SEC_CYCLES = 13_500_000,
  parameter int unsigned AMBER_HS        = 6,
  parameter int unsigned ALLRED_HS       = 4,
  parameter int unsigned GREEN_DEFAULT_S = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ciclo_esp32,
  input  logic        dest_esp32,
  output logic [11:0] semaforos,
  output logic [2:0]  fase
);

  logic [4:0]  ciclo_s1_q, ciclo_s2_q;
  logic        dest_s1_q, dest_s2_q;
  fase_t       state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        flash_on_q, flash_on_d;
  logic [11:0] semaforos_q, semaforos_d;
  logic        tick, restart, phase_end;

  // Green length in ticks, minus one, from the cycle selector sampled at green entry.
  function automatic logic [7:0] green_load(input logic [4:0] c);
    logic [5:0] g;
    g = (c == 5'd0) ? 6'(GREEN_DEFAULT_S) : {1'b0, c};
    return {1'b0, g, 1'b0} - 8'd1;
  endfunction

  function automatic logic [7:0] load_value(input fase_t s, input logic [4:0] c);
    case (s)
      NS_GREEN, EW_GREEN: return green_load(c);
      NS_AMBER, EW_AMBER: return 8'(AMBER_HS - 1);
      FLASH:              return 8'd0;
      default:            return 8'(ALLRED_HS - 1);
    endcase
  endfunction

  function automatic logic [11:0] lamp(input fase_t s, input logic on);
    case (s)
      NS_GREEN: return NS_G;
      NS_AMBER: return NS_A;
      EW_GREEN: return EW_G;
      EW_AMBER: return EW_A;
      FLASH:    return on ? FLASH_ON : 12'h000;
      default:  return ALL_RED;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ciclo_s1_q <= '0;
      ciclo_s2_q <= '0;
      dest_s1_q  <= 1'b0;
      dest_s2_q  <= 1'b0;
    end else begin
      ciclo_s1_q <= ciclo_esp32;
      ciclo_s2_q <= ciclo_s1_q;
      dest_s1_q  <= dest_esp32;
      dest_s2_q  <= dest_s1_q;
    end
  end

  tick_gen #(
    .HALF_SEC_CYCLES(HALF_SEC_CYCLES)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  // A flash request cuts a green short but lets amber and all-red run to completion.
  always_comb begin
    state_d   = state_q;
    phase_end = tick && (cnt_q == 8'd0);
    case (state_q)
      ALLRED_START: if (phase_end) state_d = dest_s2_q ? FLASH : NS_GREEN;
      NS_GREEN:     if (dest_s2_q || phase_end) state_d = NS_AMBER;
      NS_AMBER:     if (phase_end) state_d = ALLRED_1;
      ALLRED_1:     if (phase_end) state_d = dest_s2_q ? FLASH : EW_GREEN;
      EW_GREEN:     if (dest_s2_q || phase_end) state_d = EW_AMBER;
      EW_AMBER:     if (phase_end) state_d = ALLRED_2;
      ALLRED_2:     if (phase_end) state_d = dest_s2_q ? FLASH : NS_GREEN;
      FLASH:        if (!dest_s2_q) state_d = ALLRED_START;
      default:      state_d = ALLRED_START;
    endcase

    restart = (state_d != state_q);

    cnt_d = cnt_q;
    if (restart)                      cnt_d = load_value(state_d, ciclo_s2_q);
    else if (tick && cnt_q != 8'd0)   cnt_d = cnt_q - 8'd1;

    flash_on_d = flash_on_q;
    if (restart)                      flash_on_d = 1'b1;
    else if (tick && state_q == FLASH) flash_on_d = ~flash_on_q;

    semaforos_d = lamp(state_d, flash_on_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ALLRED_START;
      cnt_q       <= 8'(ALLRED_HS - 1);
      flash_on_q  <= 1'b0;
      semaforos_q <= ALL_RED;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flash_on_q  <= flash_on_d;
      semaforos_q <= semaforos_d;
    end
  end

  assign semaforos = semaforos_q;
  assign fase      = state_q;

endmodule

// File: doc/semaforo_ctrl.md
# semaforo_ctrl

Phase sequencer for the four-approach traffic-light intersection. It drives the 12-bit `semaforos` lamp bus from a Moore state machine. Green time comes from the ESP32 cycle selector `ciclo_esp32`, and the ESP32 flash request `dest_esp32` forces flashing-amber mode. It sits between the ESP32 interface pins and the lamp outputs; all of its inputs and outputs are probed by the on-chip analyzer.

## Interface

Parameters:

- `HALF_SEC_CYCLES`, default 13_500_000: clocks per half-second tick (27 MHz clk).
- `AMBER_HS`, default 6: amber duration in half-seconds.
- `ALLRED_HS`, default 4: all-red clearance in half-seconds.
- `GREEN_DEFAULT_S`, default 10: green seconds used when `ciclo_esp32 == 0`.

Ports:

- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `ciclo_esp32`  in  5  green time in seconds, 1..31; 0 selects `GREEN_DEFAULT_S`; asynchronous to `clk`
- `dest_esp32`  in  1  flash-mode request, level; asynchronous to `clk`
- `semaforos`  out  12  lamp drive; light i (0=N, 1=S, 2=E, 3=W) uses bit 3i+2 = red, 3i+1 = amber, 3i = green
- `fase`  out  3  current state encoding, for status and debug

## Operation

Input conditioning:
- `ciclo_esp32` and `dest_esp32` pass through 2-flop synchronizers.
- The synchronized `ciclo` is latched into the green register on entry to each green phase. Changes during a green do not alter that green.

States and lamp patterns:
- ALLRED_START: 0x924, lasts `ALLRED_HS` ticks.
- NS_GREEN: 0x909, lasts 2×G ticks, where G = latched ciclo (or `GREEN_DEFAULT_S` if 0).
- NS_AMBER: 0x912, lasts `AMBER_HS` ticks.
- ALLRED_1: 0x924, lasts `ALLRED_HS` ticks.
- EW_GREEN: 0x264, lasts 2×G ticks.
- EW_AMBER: 0x4A4, lasts `AMBER_HS` ticks.
- ALLRED_2: 0x924, lasts `ALLRED_HS` ticks.
- FLASH: 0x492 and 0x000 alternate each tick, starting with 0x492.

Normal sequence:
- ALLRED_START → NS_GREEN → NS_AMBER → ALLRED_1 → EW_GREEN → EW_AMBER → ALLRED_2 → NS_GREEN → …

Flash request (synchronized `dest_esp32` = 1):
- In a GREEN state: go to the matching AMBER on the next clock, truncating the green. Then continue to ALLRED, then FLASH.
- In an AMBER or ALLRED state: finish that state, then go to FLASH without entering green.
- Exit condition: synchronized `dest_esp32` = 0 while in FLASH. On the next clock go to ALLRED_START, then continue the normal sequence.

Safety invariant:
- Conflicting greens (any NS green bit together with any EW green bit) never occur.
- Every transition from green to an opposing green passes through amber and then all-red.

Timer:
- An 8-bit down-counter of ticks is loaded with duration−1 on state entry.
- The state ends on the tick where the counter is 0.
- The prescaler restarts on every state entry, so each state lasts exactly N×`HALF_SEC_CYCLES` clocks.

## Timing

- Reset (`rst` low): `semaforos` = 0x924, `fase` = ALLRED_START, counters cleared. This takes effect asynchronously.
- Reset release: ALLRED_START lasts `ALLRED_HS`×`HALF_SEC_CYCLES` clocks, then NS_GREEN.
- `semaforos` and `fase` are registered and update on the same edge as the state register (output decoded from next state), so there is zero extra latency.
- Input-to-effect latency for `dest_esp32`: 2 clocks of synchronizer plus 1 clock for the state change.
- Reset asserted mid-phase: immediate 0x924; no partial state survives.
- Simultaneous `dest_esp32` rise and phase end: the flash rule takes priority. From a green end the next state is AMBER; from an amber end it is ALLRED.
- Maximum green is 62 ticks, which fits the 8-bit counter. The tick counter never wraps.

## Structure

- Package `semaforo_pkg` contains:
  - the `fase_t` enum (3 bits);
  - lamp pattern constants `ALL_RED` = 0x924, `NS_G` = 0x909, `NS_A` = 0x912, `EW_G` = 0x264, `EW_A` = 0x4A4, `FLASH_ON` = 0x492;
  - the lamp bit-index constants.
- One sub-module `tick_gen`: a half-second prescaler with a synchronous `restart` input and a `tick` pulse output.
- FSM, timer and synchronizers live in `semaforo_ctrl`.

## Test plan

Simulation uses `HALF_SEC_CYCLES`=4, `AMBER_HS`=2, `ALLRED_HS`=2.

- Reset, then release with `ciclo`=3 → 0x924 for 8 clocks, 0x909 for 24, 0x912 for 8, 0x924 for 8, 0x264 for 24, 0x4A4 for 8.
- `ciclo`=0 → each green lasts 2×`GREEN_DEFAULT_S`×4 = 80 clocks.
- `dest_esp32` raised 5 clocks into NS_GREEN → 0x912 three clocks later, then 0x924 for 8 clocks, then 0x492 and 0x000 alternating every 4 clocks.
- `dest_esp32` dropped in FLASH → ALLRED_START (0x924, 8 clocks), then 0x909.
- `ciclo` changed from 3 to 7 mid-EW_GREEN → current green stays 24 clocks; the next NS_GREEN lasts 56.
- `rst` pulsed low mid-EW_AMBER → `semaforos` = 0x924 immediately; the sequence restarts from ALLRED_START.
- All scenarios: an assertion checks that NS green and EW green bits are never active together.
